// File: rtl/darkroom_pkg.sv
// Shared DarkRoom link definitions: receiver FSM states and link-wide constants.
// Used by both the transmitter and the receiver side.
package darkroom_pkg;

   typedef enum logic [1:0] {
      WAIT_IDLE,
      IDLE,
      SHIFT
   } rx_state_t;

   localparam int DEFAULT_WORD_WIDTH = 32;
   localparam int FRAME_COUNT_W      = 16;

endpackage

// File: rtl/darkroom_rx_fifo.sv
// Synchronous FIFO with a registered head word, full/empty tracking and
// simultaneous push/pop (a push into a full FIFO is accepted when a pop happens in the same cycle).
module darkroom_rx_fifo #(
   parameter int DATA_W = 37,
   parameter int DEPTH  = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head_data,
   output logic              valid,
   output logic              drop
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] DEPTH_C = DEPTH[PTR_W:0];

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  rd_ptr_next;
   logic [PTR_W:0]    count;
   logic [PTR_W:0]    count_next;
   logic              empty;
   logic              full;
   logic              do_push;
   logic              do_pop;

   // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      empty       = (count == '0);
      full        = (count == DEPTH_C);
      do_pop      = pop && !empty;
      do_push     = push && (!full || do_pop);
      drop        = push && !do_push;
      rd_ptr_next = do_pop ? rd_ptr + PTR_W'(1) : rd_ptr;
      count_next  = count;
      if (do_push && !do_pop) begin
         count_next = count + (PTR_W+1)'(1);
      end else if (!do_push && do_pop) begin
         count_next = count - (PTR_W+1)'(1);
      end
   end

   // NOTE: the storage array has no reset; only pointers, count and head are reset,
   // which keeps the array mappable to plain RAM/flops without a reset tree.
   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         head_data <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         rd_ptr <= rd_ptr_next;
         count  <= count_next;
         // Head holds its last value while empty; a word landing in the head slot bypasses the array.
         if (count_next != '0) begin
            head_data <= (do_push && (wr_ptr == rd_ptr_next)) ? push_data : mem[rd_ptr_next];
         end
      end
   end

   assign valid = !empty;

endmodule

// File: rtl/darkroom_spi_receiver.sv
// Mode-0 SPI slave receiver for the DarkRoom sensor link: oversampled pins, word FSM, output FIFO.
// Optional build macro DARKROOM_RX_CHECKSUM_EN adds a per-frame XOR checksum check.
module darkroom_spi_receiver
   import darkroom_pkg::*;
#(
   parameter int WORD_WIDTH          = DEFAULT_WORD_WIDTH,
   parameter int FIFO_DEPTH          = 16,
   parameter int MAX_WORDS_PER_FRAME = 32
) (
   input  logic                                   clock,
   input  logic                                   reset,
   input  logic                                   sck_i,
   input  logic                                   ss_n_i,
   input  logic                                   mosi_i,
   output logic [WORD_WIDTH-1:0]                  word_o,
   output logic [$clog2(MAX_WORDS_PER_FRAME)-1:0] word_index_o,
   output logic                                   valid_o,
   input  logic                                   ready_i,
   output logic                                   frame_done_o,
   output logic                                   frame_error_o,
   output logic                                   overflow_o,
   output logic [FRAME_COUNT_W-1:0]               frame_count_o
);

   localparam int IDX_W  = $clog2(MAX_WORDS_PER_FRAME);
   localparam int BIT_W  = $clog2(WORD_WIDTH);
   localparam int DATA_W = WORD_WIDTH + IDX_W;
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WORD_WIDTH - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MAX_WORDS_PER_FRAME - 1);

   logic [2:0] sck_sync;
   logic [2:0] ss_sync;
   logic [2:0] mosi_sync;
   logic [1:0] sync_age;
   logic       sync_primed;
   logic       sck_rise;
   logic       ss_rise;
   logic       ss_fall;
   logic       mosi_bit;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sck_sync  <= 3'b000;
         ss_sync   <= 3'b111;
         mosi_sync <= 3'b000;
         sync_age  <= 2'd0;
      end else begin
         sck_sync  <= {sck_sync[1:0], sck_i};
         ss_sync   <= {ss_sync[1:0], ss_n_i};
         mosi_sync <= {mosi_sync[1:0], mosi_i};
         if (sync_age != 2'd3) begin
            sync_age <= sync_age + 2'd1;
         end
      end
   end

   // The ss_n chain comes out of reset high; its level is only trusted once real samples fill it.
   assign sync_primed = (sync_age == 2'd3);
   assign sck_rise    = sck_sync[1] && !sck_sync[2];
   assign ss_rise     = ss_sync[1] && !ss_sync[2];
   assign ss_fall     = !ss_sync[1] && ss_sync[2];
   assign mosi_bit    = mosi_sync[2];

   rx_state_t             state;
   logic [WORD_WIDTH-2:0] shift_reg;
   logic [BIT_W-1:0]      bit_cnt;
   logic [IDX_W-1:0]      word_idx;
   logic                  idx_full;
   logic                  over_len;

   logic [WORD_WIDTH-1:0] shift_next;
   logic [BIT_W-1:0]      bit_cnt_after;
   logic                  bit_take;
   logic                  word_done;
   logic                  push;
   logic                  drop_long;
   logic                  checksum_ok;
   logic                  frame_clean;
   logic                  fifo_drop;

   always_comb begin
      shift_next    = {shift_reg, mosi_bit};
      bit_take      = (state == SHIFT) && sck_rise;
      word_done     = bit_take && (bit_cnt == LAST_BIT);
      push          = word_done && !idx_full;
      drop_long     = word_done && idx_full;
      bit_cnt_after = bit_cnt;
      if (word_done) begin
         bit_cnt_after = '0;
      end else if (bit_take) begin
         bit_cnt_after = bit_cnt + BIT_W'(1);
      end
      // Frame status already includes a bit sampled in the same cycle as the ss_n rise.
      frame_clean = (bit_cnt_after == '0) && !(over_len || drop_long) && checksum_ok;
   end

`ifdef DARKROOM_RX_CHECKSUM_EN
   logic [WORD_WIDTH-1:0] xor_acc;
   logic [WORD_WIDTH-1:0] xor_after;

   assign xor_after   = word_done ? (xor_acc ^ shift_next) : xor_acc;
   assign checksum_ok = (xor_after == '0);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         xor_acc <= '0;
      end else if (state == IDLE && ss_fall) begin
         xor_acc <= '0;
      end else if (word_done) begin
         xor_acc <= xor_after;
      end
   end
`else
   assign checksum_ok = 1'b1;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state         <= WAIT_IDLE;
         shift_reg     <= '0;
         bit_cnt       <= '0;
         word_idx      <= '0;
         idx_full      <= 1'b0;
         over_len      <= 1'b0;
         frame_done_o  <= 1'b0;
         frame_error_o <= 1'b0;
         frame_count_o <= '0;
      end else begin
         frame_done_o  <= 1'b0;
         frame_error_o <= 1'b0;
         case (state)
            WAIT_IDLE: begin
               if (sync_primed && ss_sync[1]) begin
                  state <= IDLE;
               end
            end
            IDLE: begin
               if (ss_fall) begin
                  state    <= SHIFT;
                  bit_cnt  <= '0;
                  word_idx <= '0;
                  idx_full <= 1'b0;
                  over_len <= 1'b0;
               end
            end
            SHIFT: begin
               if (bit_take) begin
                  shift_reg <= shift_next[WORD_WIDTH-2:0];
                  bit_cnt   <= bit_cnt_after;
               end
               if (push) begin
                  if (word_idx == LAST_IDX) begin
                     idx_full <= 1'b1;
                  end else begin
                     word_idx <= word_idx + IDX_W'(1);
                  end
               end
               if (drop_long) begin
                  over_len <= 1'b1;
               end
               if (ss_rise) begin
                  state <= IDLE;
                  if (frame_clean) begin
                     frame_done_o  <= 1'b1;
                     frame_count_o <= frame_count_o + FRAME_COUNT_W'(1);
                  end else begin
                     frame_error_o <= 1'b1;
                  end
               end
            end
            default: state <= WAIT_IDLE;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         overflow_o <= 1'b0;
      end else if (fifo_drop) begin
         overflow_o <= 1'b1;
      end
   end

   darkroom_rx_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (FIFO_DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data ({shift_next, word_idx}),
      .pop       (ready_i),
      .head_data ({word_o, word_index_o}),
      .valid     (valid_o),
      .drop      (fifo_drop)
   );

endmodule

// File: doc/darkroom_spi_receiver.md
# darkroom_spi_receiver

SPI slave receiver that terminates the lighthouse sensor link driven by the DarkRoom sensor aggregator. It decodes mode-0 SPI frames (sck/ss_n/mosi) into 32-bit sensor words and buffers them in a small FIFO. The FIFO feeds a valid/ready stream toward the pose-estimation side. All SPI pins are asynchronous to `clock` and are oversampled; the block contains no second clock domain.

## Interface
- `WORD_WIDTH`, 32, bits per SPI word (shift length)
- `FIFO_DEPTH`, 16, output FIFO entries, power of 2, ≥2
- `MAX_WORDS_PER_FRAME`, 32, words accepted per ss_n-low frame

- `clock`  in  1  single system clock; all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `sck_i`  in  1  SPI clock from master, async
- `ss_n_i`  in  1  SPI slave select, active low, async
- `mosi_i`  in  1  SPI data, async
- `word_o`  out  WORD_WIDTH  FIFO head data
- `word_index_o`  out  $clog2(MAX_WORDS_PER_FRAME)  position of head word within its frame
- `valid_o`  out  1  FIFO non-empty
- `ready_i`  in  1  consumer pop; pop when valid_o && ready_i
- `frame_done_o`  out  1  1-cycle pulse, clean frame end
- `frame_error_o`  out  1  1-cycle pulse, partial word or over-length frame
- `overflow_o`  out  1  sticky; word dropped because FIFO full; cleared only by reset
- `frame_count_o`  out  16  clean frames received, wraps at 2^16

## Operation
- Inputs: 2-FF synchronizers on sck_i, ss_n_i, mosi_i; a third register per line for edge detect. Sync FFs reset: ss_n chain to 1, sck and mosi chains to 0.
- SPI mode 0, MSB first. Sample synced mosi on detected sck rising edge; ignore falling edges.
- FSM states:
  - WAIT_IDLE (reset state): go to IDLE when synced ss_n = 1. This discards any frame in progress at reset release.
  - IDLE: on ss_n falling edge, go to SHIFT; clear bit_cnt and word_idx.
  - SHIFT:
    - On each sck rise, shift left and increment bit_cnt.
    - On the WORD_WIDTH-th bit: push {word, word_idx}, reset bit_cnt, increment word_idx.
    - On ss_n rising edge, go to IDLE. If bit_cnt==0 and no over-length occurred: frame_done_o pulse and frame_count_o+1. Otherwise: frame_error_o pulse, partial word discarded.
- Over-length: words with word_idx ≥ MAX_WORDS_PER_FRAME are not pushed, and the frame ends with frame_error_o.
- Push while full: word dropped, overflow_o set. Simultaneous push+pop on a full FIFO is accepted (no drop).
- sck rise and ss_n rise detected in the same cycle: take the sck bit first, then close the frame.
- Pop while empty: no effect.

## Timing
- Input latency: a pin edge is detected 3 clock cycles after it (2 sync + 1 edge register).
- Push occurs in the detect cycle D of the last bit. valid_o and word_o are valid at D+1; the FIFO head is registered.
- frame_done_o / frame_error_o are asserted in the cycle the ss_n rise is detected.
- Pop: head advances the cycle after valid_o && ready_i. Back-to-back pops sustain 1 word/cycle.
- SPI constraint: sck high and low phases must each be ≥ 3 clock periods, i.e. sck ≤ clock/6.
- Reset values: word_o=0, word_index_o=0, valid_o=0, frame_done_o=0, frame_error_o=0, overflow_o=0, frame_count_o=0. FIFO is emptied and FSM=WAIT_IDLE.

## Configuration
- `DARKROOM_RX_CHECKSUM_EN` defined:
  - Keep a running XOR of all words of the frame, including the final checksum word sent by the transmitter.
  - At a clean frame end, a nonzero XOR produces frame_error_o instead of frame_done_o, and frame_count_o is not incremented.
  - The checksum word is still pushed to the FIFO; the consumer discards it.
- Undefined: no XOR logic; frame status depends only on bit/word counts.

## Structure
- `darkroom_pkg`: state enum (WAIT_IDLE, IDLE, SHIFT), default WORD_WIDTH, frame-count width constant. The package is shared with the transmitter side.
- One sub-module: `darkroom_rx_fifo`, a synchronous FIFO with registered head, full/empty flags, and simultaneous push/pop. Synchronizers and FSM stay in the top module.

## Test plan
- One frame carrying 0xDEADBEEF, 0x00000001 at clock/8 → word_o 0xDEADBEEF idx 0, then 0x00000001 idx 1; one frame_done_o; frame_count_o=1.
- Frame with 40 bits (1 word + 8 bits) → one word pushed; frame_error_o pulse; frame_count_o unchanged.
- ready_i=0, frame of FIFO_DEPTH+2 words → first 16 words retained in order; overflow_o=1 after word 17; frame_done_o still pulses.
- FIFO full with ready_i=1 held during next push → no drop, overflow_o stays 0, order preserved.
- reset asserted mid-word, released while ss_n low, then a new full frame → nothing pushed until ss_n high; then the new frame is received correctly.
- With `DARKROOM_RX_CHECKSUM_EN`: frame 0x12345678, 0x12345678 → frame_done_o. Frame 0x12345678, 0x00000000 → frame_error_o.
